fsk_hop_ctrl: RTL and testbench
===============================

FSK_HOP_CTRL -- requirements
Module: fsk_hop_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ACC_W, default 42, rate accumulator width in bits (legal range 4..48).
REQ-002 The block SHALL have parameter IDX_W, default 2, tone index width; 2^IDX_W tone levels (legal range 1..4).
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have one clock and a synchronous active-high reset, named Clock and Reset: Clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 The block SHALL have Reset  input  1  synchronous, active-high, sampled on the rising Clock edge.
REQ-005 The block SHALL have FSK_Mode  input  2  00 off, 01 internal rate, 10 external edge, 11 external level.
REQ-006 The block SHALL have FSK_Seq_PP  input  1  0 wrap sequence, 1 ping-pong sequence.
REQ-007 The block SHALL have FSK_Last_Idx  input  IDX_W  highest tone index in the hop sequence.
REQ-008 The block SHALL have FSK_Rate  input  ACC_W  phase increment per Clock for internal hop rate.
REQ-009 The block SHALL have FSK_EXT_SIG  input  1  asynchronous external key signal.
REQ-010 The block SHALL have FSK_Idx_out  output  IDX_W  registered current tone index.
REQ-011 The block SHALL have FSK_Hop_Strobe  output  1  registered one-cycle pulse whenever FSK_Idx_out changes value.

Function
REQ-012 FSK_Rate SHALL be captured into register Rate_q every cycle; the accumulator SHALL add Rate_q, not FSK_Rate.
REQ-013 FSK_EXT_SIG SHALL pass through a two-flop synchroniser (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-014 Mode 01: acc <= (acc + Rate_q) mod 2^ACC_W each cycle; carry flag register <= overflow bit of that sum.
REQ-015 Mode 01: the index SHALL advance on the edge after the carry flag is set (one advance per carry).
REQ-016 Mode 10: the index SHALL advance on the edge where rise is 1; FSK_EXT_SIG first sampled high at edge e1 -> index changes at e3.
REQ-017 Mode 11: index <= s2 ? FSK_Last_Idx : 0 every cycle (legacy 2-FSK); same e3 latency.
REQ-018 Mode 00: index SHALL be held at 0; accumulator and carry SHALL be held at 0.
REQ-019 Wrap advance: index == FSK_Last_Idx or index > FSK_Last_Idx -> 0, else index + 1.
REQ-020 Ping-pong: direction flag up/down; up at FSK_Last_Idx -> down and index - 1; down at 0 -> up and index + 1; index > FSK_Last_Idx -> index 0, direction up.
REQ-021 FSK_Last_Idx == 0: index SHALL stay 0 and FSK_Hop_Strobe SHALL never assert in modes 01/10.
REQ-022 Any change of FSK_Mode (detected against a registered copy) SHALL clear acc, carry and direction (up) and force index to 0 on the following edge; an advance request in that same cycle SHALL be discarded.
REQ-023 FSK_Hop_Strobe SHALL be asserted in the same cycle as the new FSK_Idx_out value, for exactly one cycle, only if the value differs from the previous cycle.
REQ-024 FSK_Seq_PP changes SHALL take effect at the next advance without clearing state.

Reset
REQ-025 On Reset = 1 at a rising edge: FSK_Idx_out = 0, FSK_Hop_Strobe = 0, acc = 0, carry = 0, Rate_q = 0, s1/s2/s3 = 0, direction = up, registered mode = 00.
REQ-026 Reset SHALL override all other inputs, including mid-sequence and mid-synchronisation; no strobe SHALL be generated by reset.
REQ-027 After Reset deasserts, the first FSK_Mode value SHALL be treated as a mode change (REQ-022).

Verification (bench with ACC_W=8, IDX_W=2)
REQ-028 Mode 01, Rate=64, Last_Idx=3, wrap -> FSK_Idx_out 0,1,2,3,0 advancing every 4 cycles, one strobe per advance.
REQ-029 Mode 01, Rate=64, Last_Idx=3, ping-pong -> sequence 0,1,2,3,2,1,0,1; Last_Idx changed to 1 while index=3 -> next advance gives 0.
REQ-030 Mode 10, three FSK_EXT_SIG pulses of 3 cycles, Last_Idx=2, wrap -> 1,2,0, each change at e3 after first high sample; 1-cycle glitch still caught by s1 counts once.
REQ-031 Mode 11, Last_Idx=3, FSK_EXT_SIG toggling -> index alternates 3/0 with e3 latency; strobe on each toggle.
REQ-032 Reset asserted at index 2 mid-count, and mode switched 01->10 at index 3 -> both cases give index 0 next edge, acc 0, no spurious advance.

Source files
------------

// File: rtl/fsk_hop_ctrl.sv
// -----------------------------------------------------------------------------
// fsk_hop_ctrl
//   Tone-hop controller for an FSK modulator. It produces the current tone
//   index and a one-cycle strobe each time that index changes. The index
//   advances on one of these sources:
//     - an internal phase accumulator, advancing once per carry
//     - the rising edge of a synchronised external key signal
//     - the synchronised external key level (legacy 2-FSK)
//   The index walks either a wrap sequence or a ping-pong sequence
//   (0..last..0).
//
// Ports
//   Clock          : sole clock; all state updates on its rising edge
//   Reset          : synchronous, active-high
//   FSK_Mode       : 00 off, 01 internal rate, 10 external edge, 11 external level
//   FSK_Seq_PP     : 0 wrap sequence, 1 ping-pong sequence
//   FSK_Last_Idx   : highest tone index of the hop sequence
//   FSK_Rate       : accumulator phase increment per Clock
//   FSK_EXT_SIG    : asynchronous external key signal
//   FSK_Idx_out    : registered current tone index
//   FSK_Hop_Strobe : registered pulse, high in the cycle a new index appears
// -----------------------------------------------------------------------------
module fsk_hop_ctrl #(
  parameter int ACC_W = 42,
  parameter int IDX_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       FSK_Mode,
  input  logic             FSK_Seq_PP,
  input  logic [IDX_W-1:0] FSK_Last_Idx,
  input  logic [ACC_W-1:0] FSK_Rate,
  input  logic             FSK_EXT_SIG,
  output logic [IDX_W-1:0] FSK_Idx_out,
  output logic             FSK_Hop_Strobe
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RATE  = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  logic [ACC_W-1:0] rate_q;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic             s1, s2, s3;
  logic [1:0]       mode_q;
  logic             mode_seen;   // cleared by reset: first mode after reset counts as a change
  logic             dir_up;

  logic [ACC_W:0]   sum;
  logic             rise;
  logic             mode_chg;
  logic [IDX_W-1:0] step_idx;
  logic             step_up;
  logic [IDX_W-1:0] idx_nxt;
  logic             dir_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             carry_nxt;

  assign sum      = {1'b0, acc} + {1'b0, rate_q};
  assign rise     = s2 & ~s3;
  assign mode_chg = ~mode_seen | (FSK_Mode != mode_q);

  // Next index of the hop sequence, assuming an advance happens this cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    step_idx = FSK_Idx_out;
    step_up  = dir_up;
    if (!FSK_Seq_PP) begin
      step_idx = (FSK_Idx_out >= FSK_Last_Idx) ? '0 : FSK_Idx_out + 1'b1;
    end else if ((FSK_Idx_out > FSK_Last_Idx) || (FSK_Last_Idx == '0)) begin
      // Out of range (last index lowered) or a single-tone sequence:
      // restart from 0 going up.
      step_idx = '0;
      step_up  = 1'b1;
    end else if (dir_up) begin
      if (FSK_Idx_out == FSK_Last_Idx) begin
        step_idx = FSK_Idx_out - 1'b1;
        step_up  = 1'b0;
      end else begin
        step_idx = FSK_Idx_out + 1'b1;
      end
    end else begin
      if (FSK_Idx_out == '0) begin
        step_idx = FSK_Idx_out + 1'b1;
        step_up  = 1'b1;
      end else begin
        step_idx = FSK_Idx_out - 1'b1;
      end
    end
  end

  // Mode-dependent next state. A mode change wins over any pending advance.
  always_comb begin
    idx_nxt   = FSK_Idx_out;
    dir_nxt   = dir_up;
    acc_nxt   = '0;
    carry_nxt = 1'b0;
    if (mode_chg) begin
      idx_nxt = '0;
      dir_nxt = 1'b1;
    end else begin
      case (FSK_Mode)
        MODE_RATE: begin
          acc_nxt   = sum[ACC_W-1:0];
          carry_nxt = sum[ACC_W];
          // The carry registered last cycle triggers this cycle's advance.
          if (carry) begin
            idx_nxt = step_idx;
            dir_nxt = step_up;
          end
        end
        MODE_EDGE: begin
          if (rise) begin
            idx_nxt = step_idx;
            dir_nxt = step_up;
          end
        end
        MODE_LEVEL: idx_nxt = s2 ? FSK_Last_Idx : '0;
        MODE_OFF:   idx_nxt = '0;
        default:    idx_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      rate_q         <= '0;
      acc            <= '0;
      carry          <= 1'b0;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      mode_q         <= MODE_OFF;
      mode_seen      <= 1'b0;
      dir_up         <= 1'b1;
      FSK_Idx_out    <= '0;
      FSK_Hop_Strobe <= 1'b0;
    end else begin
      rate_q         <= FSK_Rate;
      s1             <= FSK_EXT_SIG;
      s2             <= s1;
      s3             <= s2;
      mode_q         <= FSK_Mode;
      mode_seen      <= 1'b1;
      acc            <= acc_nxt;
      carry          <= carry_nxt;
      dir_up         <= dir_nxt;
      FSK_Idx_out    <= idx_nxt;
      FSK_Hop_Strobe <= (idx_nxt != FSK_Idx_out);
    end
  end

endmodule

// File: tb/tb_fsk_hop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsk_hop_ctrl
//   Self-checking bench for fsk_hop_ctrl with ACC_W=8 and IDX_W=2.
//   The bench has three parts:
//     - directed sequences for each mode
//     - a vector table for the level mode
//     - a randomised run compared every cycle with a behavioural model
// -----------------------------------------------------------------------------
module tb_fsk_hop_ctrl;

  localparam int ACC_W   = 8;
  localparam int IDX_W   = 2;
  localparam int ACC_MOD = 1 << ACC_W;

  logic             clock;
  logic             reset;
  logic [1:0]       fsk_mode;
  logic             fsk_seq_pp;
  logic [IDX_W-1:0] fsk_last_idx;
  logic [ACC_W-1:0] fsk_rate;
  logic             fsk_ext_sig;
  logic [IDX_W-1:0] fsk_idx;
  logic             fsk_strobe;

  int n_checks = 0;
  int n_errors = 0;

  fsk_hop_ctrl #(.ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .Clock          (clock),
    .Reset          (reset),
    .FSK_Mode       (fsk_mode),
    .FSK_Seq_PP     (fsk_seq_pp),
    .FSK_Last_Idx   (fsk_last_idx),
    .FSK_Rate       (fsk_rate),
    .FSK_EXT_SIG    (fsk_ext_sig),
    .FSK_Idx_out    (fsk_idx),
    .FSK_Hop_Strobe (fsk_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_idx = 0, m_up = 1, m_acc = 0, m_carry = 0, m_rate = 0;
  int m_mode = 0, m_seen = 0, m_strobe = 0;
  int ext_hist[3] = '{0, 0, 0};   // ext_hist[k]: external sample taken k+1 edges ago

  function automatic void hop(input int idx, input int up, input int last, input int pp,
                              output int nidx, output int nup);
    nidx = idx;
    nup  = up;
    if (pp == 0) begin
      nidx = (idx >= last) ? 0 : idx + 1;
    end else if (idx > last || last == 0) begin
      nidx = 0;
      nup  = 1;
    end else if (up != 0) begin
      if (idx == last) begin nidx = idx - 1; nup = 0; end
      else nidx = idx + 1;
    end else begin
      if (idx == 0) begin nidx = 1; nup = 1; end
      else nidx = idx - 1;
    end
  endfunction

  task automatic model_edge();
    int nidx, nup, nacc, ncarry, sum, last, mode;
    bit chg, rise;
    if (reset) begin
      m_idx = 0; m_up = 1; m_acc = 0; m_carry = 0; m_rate = 0;
      m_mode = 0; m_seen = 0; m_strobe = 0;
      ext_hist = '{0, 0, 0};
      return;
    end
    last = int'(fsk_last_idx);
    mode = int'(fsk_mode);
    chg  = (m_seen == 0) || (mode != m_mode);
    // A synchronised rise is visible two edges after the first high sample.
    rise = (ext_hist[1] != 0) && (ext_hist[2] == 0);
    nidx = m_idx; nup = m_up; nacc = 0; ncarry = 0;
    if (chg) begin
      nidx = 0;
      nup  = 1;
    end else begin
      case (mode)
        1: begin
          sum    = m_acc + m_rate;
          nacc   = sum % ACC_MOD;
          ncarry = (sum >= ACC_MOD) ? 1 : 0;
          if (m_carry != 0) hop(m_idx, m_up, last, int'(fsk_seq_pp), nidx, nup);
        end
        2: if (rise) hop(m_idx, m_up, last, int'(fsk_seq_pp), nidx, nup);
        3: nidx = (ext_hist[1] != 0) ? last : 0;
        default: nidx = 0;
      endcase
    end
    m_strobe    = (nidx != m_idx) ? 1 : 0;
    m_idx       = nidx;
    m_up        = nup;
    m_acc       = nacc;
    m_carry     = ncarry;
    m_rate      = int'(fsk_rate);
    m_mode      = mode;
    m_seen      = 1;
    ext_hist[2] = ext_hist[1];
    ext_hist[1] = ext_hist[0];
    ext_hist[0] = int'(fsk_ext_sig);
  endtask

  // One clock edge; the model follows every edge and outputs are compared #1 later.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("model_idx", int'(fsk_idx), m_idx);
    check("model_strobe", int'(fsk_strobe), m_strobe);
  endtask

  task automatic hold(input int n, input int v, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check({name, "_hold_idx"}, int'(fsk_idx), v);
      check({name, "_hold_strobe"}, int'(fsk_strobe), 0);
    end
  endtask

  task automatic step(input int v, input string name);
    tick();
    check({name, "_step_idx"}, int'(fsk_idx), v);
    check({name, "_step_strobe"}, int'(fsk_strobe), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("reset_idx", int'(fsk_idx), 0);
    check("reset_strobe", int'(fsk_strobe), 0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic ext;
    int   idx;
    int   strobe;
  } vec_t;

  vec_t level_vecs[14];

  initial begin
    // Level mode, Last_Idx=3: the index follows the synchronised level two edges late.
    level_vecs = '{
      '{1'b0, 0, 0}, '{1'b0, 0, 0}, '{1'b1, 0, 0}, '{1'b1, 0, 0},
      '{1'b1, 3, 1}, '{1'b0, 3, 0}, '{1'b0, 3, 0}, '{1'b0, 0, 1},
      '{1'b1, 0, 0}, '{1'b1, 0, 0}, '{1'b0, 3, 1}, '{1'b0, 3, 0},
      '{1'b0, 0, 1}, '{1'b0, 0, 0}
    };

    reset = 1'b1; fsk_mode = 2'b01; fsk_seq_pp = 1'b0; fsk_last_idx = 2'd3;
    fsk_rate = 8'd64; fsk_ext_sig = 1'b0;

    // Internal rate, wrap: one advance every 4 cycles, first carry 4 edges after the mode edge.
    do_reset();
    hold(5, 0, "wrap");
    step(1, "wrap"); hold(3, 1, "wrap");
    step(2, "wrap"); hold(3, 2, "wrap");
    step(3, "wrap"); hold(3, 3, "wrap");
    step(0, "wrap");

    // Internal rate, ping-pong, then lower Last_Idx while at index 3.
    fsk_seq_pp = 1'b1;
    do_reset();
    hold(5, 0, "pp");
    step(1, "pp"); hold(3, 1, "pp");
    step(2, "pp"); hold(3, 2, "pp");
    step(3, "pp"); hold(3, 3, "pp");
    step(2, "pp"); hold(3, 2, "pp");
    step(1, "pp"); hold(3, 1, "pp");
    step(0, "pp"); hold(3, 0, "pp");
    step(1, "pp"); hold(3, 1, "pp");
    step(2, "pp"); hold(3, 2, "pp");
    step(3, "pp");
    fsk_last_idx = 2'd1;
    hold(3, 3, "pp_last");
    step(0, "pp_last"); hold(3, 0, "pp_last");
    step(1, "pp_last"); hold(3, 1, "pp_last");
    step(0, "pp_last");

    // Single-tone sequence never hops.
    fsk_last_idx = 2'd0; fsk_seq_pp = 1'b0;
    do_reset();
    hold(20, 0, "last0_wrap");
    fsk_seq_pp = 1'b1;
    hold(20, 0, "last0_pp");

    // External edge mode, Last_Idx=2, wrap: three 3-cycle pulses, then a 1-cycle glitch.
    fsk_mode = 2'b10; fsk_last_idx = 2'd2; fsk_seq_pp = 1'b0;
    do_reset();
    hold(3, 0, "edge");
    fsk_ext_sig = 1'b1; hold(2, 0, "edge_p1"); step(1, "edge_p1");
    fsk_ext_sig = 1'b0; hold(4, 1, "edge_p1");
    fsk_ext_sig = 1'b1; hold(2, 1, "edge_p2"); step(2, "edge_p2");
    fsk_ext_sig = 1'b0; hold(4, 2, "edge_p2");
    fsk_ext_sig = 1'b1; hold(2, 2, "edge_p3"); step(0, "edge_p3");
    fsk_ext_sig = 1'b0; hold(4, 0, "edge_p3");
    fsk_ext_sig = 1'b1; hold(1, 0, "edge_glitch");
    fsk_ext_sig = 1'b0; hold(1, 0, "edge_glitch"); step(1, "edge_glitch");
    hold(6, 1, "edge_glitch");

    // External level mode from the vector table.
    fsk_mode = 2'b11; fsk_last_idx = 2'd3; fsk_ext_sig = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      fsk_ext_sig = level_vecs[i].ext;
      tick();
      check($sformatf("level_idx[%0d]", i), int'(fsk_idx), level_vecs[i].idx);
      check($sformatf("level_strobe[%0d]", i), int'(fsk_strobe), level_vecs[i].strobe);
    end

    // Reset mid-count at index 2, then a mode switch at index 3, then a switch
    // in the cycle whose carry would have advanced the index.
    fsk_mode = 2'b01; fsk_last_idx = 2'd3; fsk_seq_pp = 1'b0; fsk_ext_sig = 1'b0;
    do_reset();
    hold(5, 0, "mid");
    step(1, "mid"); hold(3, 1, "mid");
    step(2, "mid"); hold(1, 2, "mid");
    reset = 1'b1;
    tick();
    check("mid_reset_idx", int'(fsk_idx), 0);
    check("mid_reset_strobe", int'(fsk_strobe), 0);
    reset = 1'b0;
    hold(5, 0, "post_reset");
    step(1, "post_reset"); hold(3, 1, "post_reset");
    step(2, "post_reset"); hold(3, 2, "post_reset");
    step(3, "post_reset"); hold(1, 3, "post_reset");
    fsk_mode = 2'b10;
    step(0, "switch_at3");
    hold(6, 0, "switch_at3");
    fsk_mode = 2'b01;
    hold(5, 0, "switch_carry");
    fsk_mode = 2'b10;
    hold(5, 0, "switch_carry");

    // Randomised run against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) fsk_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) fsk_seq_pp = ~fsk_seq_pp;
      if ($urandom_range(0, 59) == 0) fsk_last_idx = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) fsk_rate = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) fsk_ext_sig = ~fsk_ext_sig;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
